// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Byte-side and line-side signals of the UART receiver.
//   master : drives the serial line and the consumer acknowledge (pin + byte consumer)
//   slave  : the receiver itself
//   din        serial line, idles high, asynchronous to clk
//   data       last received byte
//   valid      byte available, held until ack
//   ack        consumer accepts data
//   frame_err  1-cycle pulse, stop bit sampled low
//   overrun    1-cycle pulse, unread byte overwritten
//   busy       receiver not idle
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 din;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ack;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output din, ack,
    input  data, valid, frame_err, overrun, busy
  );

  modport slave (
    input  din, ack,
    output data, valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
//   Serial UART receiver: 1 start bit (low), DATA_BITS data bits MSB first,
//   1 stop bit (high), CLKS_PER_BIT clocks per bit. The line is synchronised
//   through two flops and sampled at bit centres; the received byte is held in
//   a valid/ack register.
//   clk    : clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   rx     : uart_rx_if.slave (din, ack in; data, valid, frame_err, overrun, busy out)
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  rx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_din_s;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_sr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_din_s <= 1'b1;
    end else begin
      r_sync1 <= rx.din;
      r_din_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sr        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      if (rx.ack && r_valid)
        r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_din_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end

        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_din_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              // Line back high at start-bit centre: treat as a glitch.
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            r_sr  <= {r_sr[DATA_BITS-2:0], r_din_s};
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX)
              r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_din_s) begin
              // This write overrides the ack clear above, so a completion
              // coinciding with ack keeps valid high for the new byte.
              r_data  <= r_sr;
              r_valid <= 1'b1;
              if (r_valid && !rx.ack)
                r_overrun <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT: begin
          // Hold off until the line returns high so a break gives one error.
          if (r_din_s)
            r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx.data      = r_data;
  assign rx.valid     = r_valid;
  assign rx.frame_err = r_frame_err;
  assign rx.overrun   = r_overrun;
  assign rx.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic clk;
  logic rst_n;

  uart_rx_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc      = 0;
  int fall_cyc = 0;
  int rise_cyc = -1;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;
  logic valid_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and edge observer, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_if.frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_if.overrun)   ovr_cnt  = ovr_cnt + 1;
    if (rx_if.frame_err && rx_if.overrun) both_cnt = both_cnt + 1;
    if (rx_if.valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_if.valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bench-side transmitter. With ack_late set, ack is high exactly on the
  // clock edge where the receiver completes the byte (155 clocks after start).
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic ack_late);
    @(posedge clk);
    #1;
    rx_if.din = 1'b0;
    fall_cyc  = cyc;
    hold(CPB);
    for (int i = DB - 1; i >= 0; i--) begin
      rx_if.din = b[i];
      hold(CPB);
    end
    rx_if.din = stop_b;
    for (int k = 0; k < CPB; k++) begin
      @(posedge clk);
      #1;
      if (ack_late && k == 9)  rx_if.ack = 1'b1;
      if (ack_late && k == 10) rx_if.ack = 1'b0;
    end
    if (stop_b) rx_if.din = 1'b1;
  endtask

  task automatic do_ack();
    rx_if.ack = 1'b1;
    hold(1);
    rx_if.ack = 1'b0;
  endtask

  int         lat;
  int         ferr_base;
  int         ovr_base;
  logic [7:0] lb_bytes [4];

  initial begin
    rst_n        = 1'b0;
    rx_if.din    = 1'b1;
    rx_if.ack    = 1'b0;
    lb_bytes[0]  = 8'h00;
    lb_bytes[1]  = 8'hFF;
    lb_bytes[2]  = 8'h80;
    lb_bytes[3]  = 8'h01;

    // Reset state
    hold(3);
    check("rst_data",      rx_if.data,      32'h0);
    check("rst_valid",     rx_if.valid,     32'h0);
    check("rst_frame_err", rx_if.frame_err, 32'h0);
    check("rst_overrun",   rx_if.overrun,   32'h0);
    check("rst_busy",      rx_if.busy,      32'h0);
    rst_n = 1'b1;
    hold(5);

    // 0xA5, held without ack, then acked
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_data",  rx_if.data,  32'hA5);
    check("a5_valid", rx_if.valid, 32'h1);
    lat = rise_cyc - fall_cyc;
    check("a5_latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
    hold(60);
    check("a5_valid_held", rx_if.valid, 32'h1);
    check("a5_data_held",  rx_if.data,  32'hA5);
    check("a5_busy_idle",  rx_if.busy,  32'h0);
    rx_if.ack = 1'b1;
    check("a5_valid_at_ack", rx_if.valid, 32'h1);
    hold(1);
    rx_if.ack = 1'b0;
    check("a5_valid_cleared", rx_if.valid, 32'h0);
    check("a5_no_flags", (ferr_cnt - ferr_base) + (ovr_cnt - ovr_base), 0);

    // ack while valid=0 ignored
    do_ack();
    hold(2);
    check("stray_ack_valid", rx_if.valid, 32'h0);

    // Start-bit glitch: 4 clocks low
    ferr_base = ferr_cnt;
    @(posedge clk);
    #1;
    rx_if.din = 1'b0;
    hold(4);
    check("glitch_busy_hi", rx_if.busy, 32'h1);
    rx_if.din = 1'b1;
    hold(10);
    check("glitch_busy_lo",  rx_if.busy,  32'h0);
    check("glitch_valid",    rx_if.valid, 32'h0);
    check("glitch_no_ferr",  ferr_cnt - ferr_base, 0);

    // 0x3C with low stop bit, line held low 40 more clocks (break)
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_busy_wait", rx_if.busy, 32'h1);
    hold(40);
    check("ferr_busy_break", rx_if.busy, 32'h1);
    rx_if.din = 1'b1;
    hold(6);
    check("ferr_count", ferr_cnt - ferr_base, 1);
    check("ferr_valid", rx_if.valid, 32'h0);
    check("ferr_data",  rx_if.data,  32'hA5);
    check("ferr_busy_lo", rx_if.busy, 32'h0);
    send_frame(8'h81, 1'b1, 1'b0);
    check("after_ferr_data",  rx_if.data,  32'h81);
    check("after_ferr_valid", rx_if.valid, 32'h1);
    do_ack();
    check("after_ferr_ack", rx_if.valid, 32'h0);

    // Back-to-back 0x12, 0x34 without ack
    ovr_base  = ovr_cnt;
    ferr_base = ferr_cnt;
    send_frame(8'h12, 1'b1, 1'b0);
    check("b2b_first_data", rx_if.data, 32'h12);
    check("b2b_no_ovr_yet", ovr_cnt - ovr_base, 0);
    send_frame(8'h34, 1'b1, 1'b0);
    check("b2b_data",    rx_if.data,  32'h34);
    check("b2b_valid",   rx_if.valid, 32'h1);
    check("b2b_overrun", ovr_cnt - ovr_base, 1);
    check("b2b_no_ferr", ferr_cnt - ferr_base, 0);

    // Completion on the same edge as ack: valid stays, no overrun
    ovr_base = ovr_cnt;
    send_frame(8'h56, 1'b1, 1'b1);
    check("ackcoll_data",  rx_if.data,  32'h56);
    check("ackcoll_valid", rx_if.valid, 32'h1);
    check("ackcoll_no_ovr", ovr_cnt - ovr_base, 0);
    do_ack();
    check("ackcoll_cleared", rx_if.valid, 32'h0);

    // Reset after 3 data bits of 0x5A (0,1,0 MSB first)
    @(posedge clk);
    #1;
    rx_if.din = 1'b0;
    hold(CPB);
    rx_if.din = 1'b0;
    hold(CPB);
    rx_if.din = 1'b1;
    hold(CPB);
    rx_if.din = 1'b0;
    hold(CPB);
    check("mid_busy_before_rst", rx_if.busy, 32'h1);
    rst_n = 1'b0;
    hold(2);
    check("mid_rst_data",      rx_if.data,      32'h0);
    check("mid_rst_valid",     rx_if.valid,     32'h0);
    check("mid_rst_frame_err", rx_if.frame_err, 32'h0);
    check("mid_rst_overrun",   rx_if.overrun,   32'h0);
    check("mid_rst_busy",      rx_if.busy,      32'h0);
    rx_if.din = 1'b1;
    rst_n     = 1'b1;
    hold(5);
    check("mid_post_busy", rx_if.busy, 32'h0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check("mid_ff_data",  rx_if.data,  32'hFF);
    check("mid_ff_valid", rx_if.valid, 32'h1);
    do_ack();

    // Loopback-style sequence with ack after each byte
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    for (int i = 0; i < 4; i++) begin
      send_frame(lb_bytes[i], 1'b1, 1'b0);
      check("lb_data",  rx_if.data,  {24'h0, lb_bytes[i]});
      check("lb_valid", rx_if.valid, 32'h1);
      do_ack();
      check("lb_acked", rx_if.valid, 32'h0);
    end
    check("lb_no_ferr", ferr_cnt - ferr_base, 0);
    check("lb_no_ovr",  ovr_cnt - ovr_base, 0);

    check("flags_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
